// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: iterative AES inverse SubBytes over a 128-bit state using LANES shared S-boxes

module inv_sub_byte (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    // Byte x of the table sits at bits [2047-8x -: 8], so index 0 is the MSB byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    assign out_byte = INV_SBOX[{~in_byte, 3'b111} -: 8];
endmodule

module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [127:0] state_in,
    output logic         done_valid,
    input  logic         done_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int W = 8 * LANES;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  out_q, out_d;
    logic [6:0]    base;
    logic [W-1:0]  beat_in, beat_out;

    assign base    = 7'(127 - W * int'(cnt_q));
    assign beat_in = work_q[base -: W];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        inv_sub_byte u_sb (
            .in_byte (beat_in[W-1-8*j -: 8]),
            .out_byte(beat_out[W-1-8*j -: 8])
        );
    end

    // Next-state: flush wins, RUN transforms one beat per cycle, IDLE/DONE accept or retire.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_d       = out_q;
        start_ready = !flush && (state_q == IDLE || (state_q == DONE && done_ready));
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            work_d[base -: W] = beat_out;
            if (cnt_q == CW'(BEATS - 1)) begin
                state_d = DONE;
                cnt_d   = '0;
                out_d   = work_d;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (start_valid && start_ready) begin
            state_d = RUN;
            cnt_d   = '0;
            work_d  = state_in;
        end else if (state_q != DONE || done_ready) begin
            state_d = IDLE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    assign done_valid = state_q == DONE;
    assign busy       = state_q != IDLE;
    assign state_out  = out_q;
endmodule
